sd_sector_read: RTL and testbench
=================================

# sd_sector_read

Single-block SPI-mode read engine for the SD controller; sits directly downstream of the card initialisation stage and is enabled by its `init_ok`. On request it issues CMD17 for a 32-bit sector address, checks the R1 response, hunts for the 0xFE start token, and streams the 512 data bytes out one byte per strobe. The trailing CRC16 is then consumed, and the card bus is released to idle.

## Interface
Parameters:
- `NCR_MAX`, 64: max bit clocks from end of command to R1 start bit.
- `TOKEN_TIMEOUT`, 65535: max bit clocks from R1 to start token.
- `DUMMY_CLKS`, 8: CS-high clocks after each transaction.

Ports:
- `SD_CK`  in  1  sole clock; also the SPI clock to the card.
- `rst`  in  1  synchronous, active-high reset.
- `init_ok`  in  1  card initialised; `rd_req` is ignored while low.
- `rd_req`  in  1  start pulse; sampled only in IDLE.
- `sec_addr`  in  32  sector address, latched with `rd_req`.
- `rd_busy`  out  1  high from the accepted request to `rd_done`.
- `rd_data`  out  8  received byte, MSB first on the wire.
- `rd_valid`  out  1  one-cycle strobe per byte.
- `rd_index`  out  9  byte number 0..511, valid with `rd_valid`.
- `rd_done`  out  1  one-cycle end-of-transaction pulse.
- `rd_err`  out  1  qualifies `rd_done`; 1 means failure.
- `err_code`  out  2  0=none, 1=R1 timeout, 2=R1 nonzero, 3=token timeout/error token.
- `SD_MISO`  in  1  card data out.
- `SD_MOSI`  out  1  card data in.
- `SD_CSn`  out  1  card chip select, active low.

## Operation
- FSM states:
  - IDLE → CMD: on `rd_req & init_ok`. Latch the address, load the 48-bit frame {0x51, addr, 0xFF}, CSn low.
  - CMD → R1WAIT: after 48 bits, MSB first.
  - R1WAIT: MOSI=1. The first 0 on MISO starts an 8-bit capture.
    - More than `NCR_MAX` clocks → RELEASE, err 1.
    - R1 != 0x00 → RELEASE, err 2.
    - R1 == 0x00 → TOKEN.
  - TOKEN: shift MISO bitwise and compare the last 8 bits.
    - 0xFE → DATA.
    - Pattern 000xxxxx (error token) or `TOKEN_TIMEOUT` clocks → RELEASE, err 3.
  - DATA: 4096 bits. Every 8th bit assert `rd_valid` with the byte and index. After byte 511 → CRC.
  - CRC: 16 bits consumed → RELEASE.
  - RELEASE: CSn high, MOSI high for `DUMMY_CLKS` clocks, then pulse `rd_done` (+`rd_err`/`err_code`) → IDLE.
- `rd_req` while busy is ignored; no queueing.
- `init_ok` falling mid-transaction does not abort; the transaction completes.
- Counters saturate at 0; byte index wraps never (bounded by 512).

## Timing
- MISO is sampled on the rising edge of `SD_CK`.
- MOSI and CSn are launched from negedge output registers fed by posedge state.
- Reset (sync on posedge) values:
  - State IDLE.
  - `SD_CSn`=1, `SD_MOSI`=1.
  - `rd_busy`, `rd_valid`, `rd_done`, `rd_err` = 0.
  - `rd_data`=0, `rd_index`=0, `err_code`=0.
- Reset mid-transaction: outputs return to reset values on the next edge; no `rd_done` is issued.
- `rd_busy` rises the cycle after `rd_req` is accepted and falls in the same cycle `rd_done` pulses.
- First `rd_valid` comes 8 clocks after the last token bit; strobes are exactly 8 clocks apart.
- Ideal total: 48 + Ncr + 8 + Nac + 8 + 4096 + 16 + `DUMMY_CLKS` clocks.

## Configuration
- `SD_RD_CRC16_EN`:
  - When defined: a CRC16-CCITT (poly 0x1021, init 0) runs over the data bits; the received CRC is compared in CRC state. On mismatch `rd_done` asserts with `rd_err`=1 and `err_code`=3; data was already streamed.
  - When undefined: the CRC bits are clocked and discarded, and `rd_err` never reflects data integrity.

## Structure
- Shared package `sd_pkg`: command index constants (CMD17=6'd17, start token 8'hFE), frame width 48, block length 512, err_code encodings, FSM state encoding.
- Sub-module `sd_crc16` (serial, 1 bit/clock, clear/enable/bit in, 16-bit out); instantiated only under `SD_RD_CRC16_EN`.

## Test plan
- **Nominal read:** `init_ok`=1, `rd_req`, addr 0x00001234 → MOSI frame 0x51_00001234_FF. Card model R1=0x00 after 8 clocks, token, bytes i&0xFF → 512 strobes with `rd_data`=index[7:0], then `rd_done`, `rd_err`=0.
- **R1 error:** card answers 0x04 → no `rd_valid`; `rd_done` with `rd_err`=1, `err_code`=2; CSn high for 8 clocks.
- **R1 timeout:** MISO held 1 → `rd_done` after 48+64 clocks plus release, `err_code`=1.
- **Error token:** card sends 0x08 instead of 0xFE → `err_code`=3, zero strobes.
- **Gating:** `rd_req` with `init_ok`=0, and a second `rd_req` during DATA → both ignored; CSn stays high or the transaction is unaffected.
- **CRC (with `SD_RD_CRC16_EN`):** corrupt one CRC bit → `rd_err`=1, `err_code`=3. Correct CRC → `rd_err`=0.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants and types for the SD SPI-mode controller blocks.
package sd_pkg;

    localparam logic [5:0]  CMD17       = 6'd17;
    localparam logic [7:0]  START_TOKEN = 8'hFE;
    localparam int          FRAME_W     = 48;
    localparam int          BLOCK_LEN   = 512;
    localparam logic [15:0] CRC16_POLY  = 16'h1021;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_R1_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_R1_NONZERO = 2'd2;
    localparam logic [1:0] ERR_TOKEN      = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_R1WAIT  = 3'd2,
        ST_TOKEN   = 3'd3,
        ST_DATA    = 3'd4,
        ST_CRC     = 3'd5,
        ST_RELEASE = 3'd6
    } state_t;

    // Command frame: start bits 01, index, argument, and a dummy 0xFF
    // trailer (CRC7 is ignored by cards in SPI mode once CMD0/CMD8 are done).
    function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, 8'hFF};
    endfunction

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16-CCITT (poly 0x1021, init 0), one bit per clock, MSB first.
module sd_crc16
    import sd_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;
    logic        w_fb;

    assign w_fb  = r_crc[15] ^ i_bit;
    assign o_crc = r_crc;

    // Shift one received bit through the LFSR when enabled.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_crc <= 16'h0000;
        end else if (i_en) begin
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/sd_sector_read.sv
// Single-block SPI-mode sector read engine (CMD17 -> R1 -> token -> 512 bytes -> CRC16).
// Optional: define SD_RD_CRC16_EN to check the trailing CRC16 against the data.
//
// state   | meaning
// IDLE    | bus released, waiting for rd_req & init_ok
// CMD     | shifting the 48-bit CMD17 frame out on MOSI
// R1WAIT  | hunting for the R1 start bit, then capturing 8 bits
// TOKEN   | bitwise search of MISO for the start token or an error token
// DATA    | 4096 data bits, one rd_valid strobe per byte
// CRC     | 16 trailing CRC bits consumed (and checked when enabled)
// RELEASE | CSn high with MOSI high for DUMMY_CLKS clocks, then rd_done
module sd_sector_read
    import sd_pkg::*;
#(
    parameter int NCR_MAX       = 64,
    parameter int TOKEN_TIMEOUT = 65535,
    parameter int DUMMY_CLKS    = 8
) (
    input  logic        SD_CK,
    input  logic        rst,
    input  logic        init_ok,
    input  logic        rd_req,
    input  logic [31:0] sec_addr,
    output logic        rd_busy,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic [8:0]  rd_index,
    output logic        rd_done,
    output logic        rd_err,
    output logic [1:0]  err_code,
    input  logic        SD_MISO,
    output logic        SD_MOSI,
    output logic        SD_CSn
);

    localparam logic [8:0] LAST_IDX = 9'(BLOCK_LEN - 1);

    state_t      r_state, w_state_nxt;
    logic [47:0] r_frame;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic        r_r1_cap;
    logic        r_full;
    logic [7:0]  r_shift;
    logic [8:0]  r_idx;
    logic [1:0]  r_err_pend;
    logic        r_busy, r_valid, r_done, r_err;
    logic [7:0]  r_data;
    logic [8:0]  r_index;
    logic [1:0]  r_err_code;
    logic        r_mosi, r_csn;

    logic [7:0]  w_sh;
    logic        w_accept;
    logic        w_tok_eval;
    logic        w_err_set;
    logic [1:0]  w_err_val;
    logic        w_crc_bad;
    logic        w_mosi, w_csn;

    assign w_sh       = {r_shift[6:0], SD_MISO};
    assign w_accept   = (r_state == ST_IDLE) && rd_req && init_ok;
    // The token window is only judged once 8 fresh bits have arrived, so the
    // tail of R1 can never be mistaken for an error token.
    assign w_tok_eval = r_full || (r_bit == 3'd0);

`ifdef SD_RD_CRC16_EN
    logic [15:0] r_crc_rx;
    logic [15:0] w_crc_calc;

    sd_crc16 u_crc (
        .i_clk (SD_CK),
        .i_rst (rst),
        .i_clr (w_accept),
        .i_en  (r_state == ST_DATA),
        .i_bit (SD_MISO),
        .o_crc (w_crc_calc)
    );

    // Collect the received CRC16 while in CRC state.
    always_ff @(posedge SD_CK) begin
        if (rst) begin
            r_crc_rx <= 16'h0000;
        end else if (r_state == ST_CRC) begin
            r_crc_rx <= {r_crc_rx[14:0], SD_MISO};
        end
    end

    assign w_crc_bad = ({r_crc_rx[14:0], SD_MISO} != w_crc_calc);
`else
    assign w_crc_bad = 1'b0;
`endif

    // State register.
    always_ff @(posedge SD_CK) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and error classification.
    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        w_err_val   = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (r_cnt == 16'd0) w_state_nxt = ST_R1WAIT;
            end
            ST_R1WAIT: begin
                if (r_r1_cap) begin
                    if (r_bit == 3'd0) begin
                        if (w_sh == 8'h00) begin
                            w_state_nxt = ST_TOKEN;
                        end else begin
                            w_state_nxt = ST_RELEASE;
                            w_err_set   = 1'b1;
                            w_err_val   = ERR_R1_NONZERO;
                        end
                    end
                end else if (SD_MISO && (r_cnt == 16'd0)) begin
                    w_state_nxt = ST_RELEASE;
                    w_err_set   = 1'b1;
                    w_err_val   = ERR_R1_TIMEOUT;
                end
            end
            ST_TOKEN: begin
                if (w_tok_eval && (w_sh == START_TOKEN)) begin
                    w_state_nxt = ST_DATA;
                end else if ((w_tok_eval && (w_sh[7:5] == 3'b000)) || (r_cnt == 16'd0)) begin
                    w_state_nxt = ST_RELEASE;
                    w_err_set   = 1'b1;
                    w_err_val   = ERR_TOKEN;
                end
            end
            ST_DATA: begin
                if ((r_bit == 3'd0) && (r_idx == LAST_IDX)) w_state_nxt = ST_CRC;
            end
            ST_CRC: begin
                if (r_cnt == 16'd0) begin
                    w_state_nxt = ST_RELEASE;
                    if (w_crc_bad) begin
                        w_err_set = 1'b1;
                        w_err_val = ERR_TOKEN;
                    end
                end
            end
            ST_RELEASE: begin
                if (r_cnt == 16'd0) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: per-state shifting/counting, then counter loads on state entry.
    always_ff @(posedge SD_CK) begin
        if (rst) begin
            r_frame    <= 48'hFFFF_FFFF_FFFF;
            r_cnt      <= 16'd0;
            r_bit      <= 3'd0;
            r_r1_cap   <= 1'b0;
            r_full     <= 1'b0;
            r_shift    <= 8'hFF;
            r_idx      <= 9'd0;
            r_err_pend <= ERR_NONE;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_data     <= 8'h00;
            r_index    <= 9'd0;
            r_err_code <= ERR_NONE;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;

            case (r_state)
                ST_CMD: begin
                    r_frame <= {r_frame[46:0], 1'b1};
                    if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
                end
                ST_R1WAIT: begin
                    if (r_r1_cap) begin
                        r_shift <= w_sh;
                        r_bit   <= r_bit - 3'd1;
                    end else if (!SD_MISO) begin
                        r_r1_cap <= 1'b1;
                        r_shift  <= w_sh;
                        r_bit    <= 3'd6;
                    end else if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_TOKEN: begin
                    r_shift <= w_sh;
                    if (r_bit == 3'd0) r_full <= 1'b1;
                    else               r_bit  <= r_bit - 3'd1;
                    if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
                end
                ST_DATA: begin
                    r_shift <= w_sh;
                    r_bit   <= r_bit - 3'd1;
                    if (r_bit == 3'd0) begin
                        r_data  <= w_sh;
                        r_valid <= 1'b1;
                        r_index <= r_idx;
                        if (r_idx != LAST_IDX) r_idx <= r_idx + 9'd1;
                    end
                end
                ST_CRC, ST_RELEASE: begin
                    if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
                end
                default: ;
            endcase

            if (w_err_set) r_err_pend <= w_err_val;

            if (w_state_nxt != r_state) begin
                case (w_state_nxt)
                    ST_CMD: begin
                        r_frame    <= cmd_frame(CMD17, sec_addr);
                        r_cnt      <= 16'(FRAME_W - 1);
                        r_busy     <= 1'b1;
                        r_err_pend <= ERR_NONE;
                    end
                    ST_R1WAIT: begin
                        // Start bit may arrive on clock NCR_MAX at the latest.
                        r_cnt    <= 16'(NCR_MAX - 1);
                        r_r1_cap <= 1'b0;
                    end
                    ST_TOKEN: begin
                        r_cnt  <= 16'(TOKEN_TIMEOUT - 1);
                        r_bit  <= 3'd7;
                        r_full <= 1'b0;
                    end
                    ST_DATA: begin
                        r_bit <= 3'd7;
                        r_idx <= 9'd0;
                    end
                    ST_CRC: begin
                        r_cnt <= 16'd15;
                    end
                    ST_RELEASE: begin
                        r_cnt <= 16'(DUMMY_CLKS - 1);
                    end
                    ST_IDLE: begin
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_err      <= (r_err_pend != ERR_NONE);
                        r_err_code <= r_err_pend;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_mosi = (r_state == ST_CMD) ? r_frame[47] : 1'b1;
    assign w_csn  = (r_state == ST_IDLE) || (r_state == ST_RELEASE);

    // Launch MOSI/CSn on the falling edge so the card sees them settled at the next rise.
    always_ff @(negedge SD_CK) begin
        if (rst) begin
            r_mosi <= 1'b1;
            r_csn  <= 1'b1;
        end else begin
            r_mosi <= w_mosi;
            r_csn  <= w_csn;
        end
    end

    assign rd_busy  = r_busy;
    assign rd_data  = r_data;
    assign rd_valid = r_valid;
    assign rd_index = r_index;
    assign rd_done  = r_done;
    assign rd_err   = r_err;
    assign err_code = r_err_code;
    assign SD_MOSI  = r_mosi;
    assign SD_CSn   = r_csn;

endmodule

// File: tb/tb_sd_sector_read.sv
// Bench for sd_sector_read: SPI card model plus scoreboards for command
// frames, data strobes and end-of-transaction results.
module tb_sd_sector_read;

    localparam int TT = 200;

`ifdef SD_RD_CRC16_EN
    localparam logic [2:0] CRC_BAD_RES = 3'b111;
`else
    localparam logic [2:0] CRC_BAD_RES = 3'b000;
`endif

    logic        SD_CK = 1'b0;
    logic        rst = 1'b1;
    logic        init_ok = 1'b0;
    logic        rd_req = 1'b0;
    logic [31:0] sec_addr = 32'h0;
    logic        rd_busy, rd_valid, rd_done, rd_err;
    logic [7:0]  rd_data;
    logic [8:0]  rd_index;
    logic [1:0]  err_code;
    logic        SD_MISO = 1'b1;
    logic        SD_MOSI, SD_CSn;

    always #5 SD_CK = ~SD_CK;

    sd_sector_read #(
        .NCR_MAX(64), .TOKEN_TIMEOUT(TT), .DUMMY_CLKS(8)
    ) dut (
        .SD_CK(SD_CK), .rst(rst), .init_ok(init_ok), .rd_req(rd_req),
        .sec_addr(sec_addr), .rd_busy(rd_busy), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_index(rd_index), .rd_done(rd_done),
        .rd_err(rd_err), .err_code(err_code), .SD_MISO(SD_MISO),
        .SD_MOSI(SD_MOSI), .SD_CSn(SD_CSn)
    );

    bit          miso_q[$];
    logic [16:0] exp_q[$];
    logic [2:0]  exp_done[$];
    logic [47:0] exp_cmd[$];

    int n_vec = 0, n_miss = 0;
    int busy_cyc = 0, rel_cyc = 0, n_strobe = 0, last_strobe = 0, first_strobe = 0;
    int gap_bad = 0, n_done = 0, n_cmd = 0, n_exp_strobes = 0;

    logic [47:0] cmd_sh = 48'h0;
    int          cmd_cnt = 0;
    bit          card_active = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int k = 0; k < 8; k++) r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        return r;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) miso_q.push_back(b[k]);
    endtask

    // Card: capture the command frame while selected, then play the response stream.
    always @(posedge SD_CK) begin
        if (!SD_CSn) begin
            cmd_sh = {cmd_sh[46:0], SD_MOSI};
            if (!card_active) begin
                cmd_cnt++;
                if (cmd_cnt == 48) begin
                    card_active = 1'b1;
                    n_cmd++;
                    if (exp_cmd.size() == 0) check("cmd_extra", 64'(exp_cmd.size()), 1);
                    else                     check("cmd_frame", cmd_sh, exp_cmd.pop_front());
                end
            end
        end else begin
            cmd_cnt     = 0;
            card_active = 1'b0;
        end
    end

    always @(negedge SD_CK) begin
        if (card_active && miso_q.size() > 0) SD_MISO = miso_q.pop_front();
        else                                  SD_MISO = 1'b1;
    end

    // Monitor: outputs sampled 1 ns after the falling edge.
    always @(negedge SD_CK) begin
        #1;
        if (rd_busy) begin
            busy_cyc++;
            if (SD_CSn) rel_cyc++;
        end
        if (rd_valid) begin
            n_strobe++;
            if (n_strobe == 1) first_strobe = busy_cyc;
            else if (busy_cyc - last_strobe != 8) gap_bad++;
            last_strobe = busy_cyc;
            if (exp_q.size() == 0) check("strobe_extra", 64'(exp_q.size()), 1);
            else                   check("strobe", {rd_index, rd_data}, exp_q.pop_front());
        end
        if (rd_done) begin
            n_done++;
            if (exp_done.size() == 0) check("done_extra", 64'(exp_done.size()), 1);
            else                      check("done_res", {rd_err, err_code}, exp_done.pop_front());
        end
    end

    task automatic load_card(input logic [31:0] addr, input int ncr, input logic [7:0] r1,
                             input int nac, input logic [7:0] tok, input bit bad_crc);
        logic [15:0] crc;
        logic [7:0]  b;
        miso_q.delete();
        exp_q.delete();
        n_exp_strobes = 0;
        repeat (ncr) miso_q.push_back(1'b1);
        push_byte(r1);
        if (r1 == 8'h00) begin
            repeat (nac) push_byte(8'hFF);
            push_byte(tok);
            if (tok == 8'hFE) begin
                crc = 16'h0000;
                for (int i = 0; i < 512; i++) begin
                    b = 8'(i) ^ addr[31:24];
                    exp_q.push_back({9'(i), b});
                    push_byte(b);
                    crc = crc_byte(crc, b);
                end
                if (bad_crc) crc ^= 16'h0100;
                push_byte(crc[15:8]);
                push_byte(crc[7:0]);
                n_exp_strobes = 512;
            end
        end
        exp_cmd.push_back({8'h51, addr, 8'hFF});
        busy_cyc = 0; rel_cyc = 0; n_strobe = 0; first_strobe = 0;
    endtask

    task automatic run_read(input logic [31:0] addr, input int ncr, input logic [7:0] r1,
                            input int nac, input logic [7:0] tok, input bit bad_crc,
                            input bit poke, input logic [2:0] exp_res, input int exp_total);
        int d0;
        load_card(addr, ncr, r1, nac, tok, bad_crc);
        exp_done.push_back(exp_res);
        d0 = n_done;
        @(negedge SD_CK); sec_addr = addr; rd_req = 1'b1;
        @(negedge SD_CK); rd_req = 1'b0;
        for (int c = 0; c < exp_total + 100 && n_done == d0; c++) begin
            @(negedge SD_CK);
            if (poke && c == 300) begin
                rd_req = 1'b1; sec_addr = ~addr; init_ok = 1'b0;
            end else if (poke && c == 301) begin
                rd_req = 1'b0;
            end
        end
        #2;
        check("done_seen", n_done - d0, 1);
        check("strobes", n_strobe, n_exp_strobes);
        check("release_clks", rel_cyc, 8);
        check("busy_clks", busy_cyc, exp_total);
        check("sb_empty", 64'(exp_q.size()), 0);
        if (n_exp_strobes > 0) check("first_strobe", first_strobe, 48 + ncr + 8 + nac * 8 + 8 + 8 + 1);
        init_ok = 1'b1;
        repeat (20) @(negedge SD_CK);
        #2;
        check("idle_after", {rd_busy, SD_CSn}, 2'b01);
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        repeat (3) @(negedge SD_CK);
        #2;
        check("rst_csn", SD_CSn, 1);
        check("rst_mosi", SD_MOSI, 1);
        check("rst_busy", rd_busy, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_done", rd_done, 0);
        check("rst_err", {rd_err, err_code}, 0);
        check("rst_data", {rd_index, rd_data}, 0);
        @(negedge SD_CK); rst = 1'b0;

        // rd_req while init_ok is low is ignored
        @(negedge SD_CK); sec_addr = 32'hDEAD_BEEF; rd_req = 1'b1;
        @(negedge SD_CK); rd_req = 1'b0;
        repeat (80) @(negedge SD_CK);
        #2;
        check("gate_busy", rd_busy, 0);
        check("gate_csn", SD_CSn, 1);
        check("gate_cmds", n_cmd, 0);
        init_ok = 1'b1;

        // nominal; second rd_req and init_ok drop during DATA
        run_read(32'h0000_1234, 8, 8'h00, 2, 8'hFE, 1'b0, 1'b1, 3'b000, 4208);
        // R1 nonzero
        run_read(32'h0000_ABCD, 8, 8'h04, 0, 8'hFE, 1'b0, 1'b0, 3'b110, 72);
        // R1 timeout: MISO stays high
        run_read(32'h0000_0001, 100, 8'hFF, 0, 8'hFE, 1'b0, 1'b0, 3'b101, 120);
        // error token straight after R1
        run_read(32'h0000_0002, 8, 8'h00, 0, 8'h08, 1'b0, 1'b0, 3'b111, 80);
        // token timeout
        run_read(32'h0000_0003, 3, 8'h00, 0, 8'hFF, 1'b0, 1'b0, 3'b111, 48 + 11 + TT + 8);
        // corrupted CRC, different data pattern, R1 start on first clock
        run_read(32'h5A00_0010, 0, 8'h00, 1, 8'hFE, 1'b1, 1'b0, CRC_BAD_RES, 4192);

        // reset in the middle of DATA: no rd_done, outputs back to reset values
        load_card(32'h0000_0077, 8, 8'h00, 1, 8'hFE, 1'b0);
        d0 = n_done;
        @(negedge SD_CK); sec_addr = 32'h0000_0077; rd_req = 1'b1;
        @(negedge SD_CK); rd_req = 1'b0;
        repeat (400) @(negedge SD_CK);
        rst = 1'b1;
        @(negedge SD_CK);
        #2;
        check("mid_rst_busy", rd_busy, 0);
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_bus", {SD_CSn, SD_MOSI}, 2'b11);
        check("mid_rst_data", {rd_index, rd_data}, 0);
        check("mid_rst_err", {rd_err, err_code}, 0);
        rst = 1'b0;
        repeat (30) @(negedge SD_CK);
        check("mid_rst_no_done", n_done - d0, 0);
        exp_q.delete();

        // latest legal R1 start bit (63 idle clocks), token right after R1
        run_read(32'h0000_4321, 63, 8'h00, 0, 8'hFE, 1'b0, 1'b0, 3'b000, 4247);

        check("strobe_gap", gap_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
